// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// One-cycle capture latency; stall_in holds the slot, flush and load-use write a bubble.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            id_valid_in,
  input  logic [XLEN-1:0] pc_id_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] reg_1_id_in,
  input  logic [XLEN-1:0] reg_2_id_in,
  input  logic [XLEN-1:0] imm_data_id_in,
  input  logic [4:0]      alu_op_id_in,
  input  logic [1:0]      alu_mode_select_id_in,
  input  logic            reg_write_id_in,
  input  logic            mem_read_id_in,
  input  logic            mem_write_id_in,
  input  logic [4:0]      ex_mem_rd_in,
  input  logic            ex_mem_reg_write_in,
  input  logic [XLEN-1:0] ex_mem_result_in,
  input  logic [4:0]      mem_wb_rd_in,
  input  logic            mem_wb_reg_write_in,
  input  logic [XLEN-1:0] mem_wb_result_in,
  output logic [XLEN-1:0] pc_ex,
  output logic [XLEN-1:0] reg_1_out,
  output logic [XLEN-1:0] reg_2_out,
  output logic [XLEN-1:0] imm_data_out,
  output logic [4:0]      alu_op_out,
  output logic [1:0]      alu_mode_select_out,
  output logic [4:0]      rd_addr_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            ex_valid_out,
  output logic            load_use_stall_out
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] reg_1;
    logic [XLEN-1:0] reg_2;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic [1:0]      alu_mode;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;
  logic load_use;

  // rs2 is compared even for I-type; the spurious stall is accepted for simplicity.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid_in &&
               ((rs1_addr_in == ex_q.rd) || (rs2_addr_in == ex_q.rd));
  end

  always_comb begin
    ex_d = ex_q;
    if (flush_in) begin
      ex_d = '0;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = id_valid_in;
      ex_d.pc        = pc_id_in;
      ex_d.rs1       = rs1_addr_in;
      ex_d.rs2       = rs2_addr_in;
      ex_d.rd        = rd_addr_in;
      ex_d.reg_1     = reg_1_id_in;
      ex_d.reg_2     = reg_2_id_in;
      ex_d.imm       = imm_data_id_in;
      ex_d.alu_op    = alu_op_id_in;
      ex_d.alu_mode  = alu_mode_select_id_in;
      ex_d.reg_write = reg_write_id_in;
      ex_d.mem_read  = mem_read_id_in;
      ex_d.mem_write = mem_write_id_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // EX/MEM is checked first so the youngest producer wins.
  always_comb begin
    reg_1_out = ex_q.reg_1;
    if ((ex_q.rs1 != 5'd0) && ex_mem_reg_write_in && (ex_mem_rd_in == ex_q.rs1)) begin
      reg_1_out = ex_mem_result_in;
    end else if ((ex_q.rs1 != 5'd0) && mem_wb_reg_write_in && (mem_wb_rd_in == ex_q.rs1)) begin
      reg_1_out = mem_wb_result_in;
    end
    reg_2_out = ex_q.reg_2;
    if ((ex_q.rs2 != 5'd0) && ex_mem_reg_write_in && (ex_mem_rd_in == ex_q.rs2)) begin
      reg_2_out = ex_mem_result_in;
    end else if ((ex_q.rs2 != 5'd0) && mem_wb_reg_write_in && (mem_wb_rd_in == ex_q.rs2)) begin
      reg_2_out = mem_wb_result_in;
    end
  end

  always_comb begin
    pc_ex               = ex_q.pc;
    imm_data_out        = ex_q.imm;
    alu_op_out          = ex_q.alu_op;
    alu_mode_select_out = ex_q.alu_mode;
    rd_addr_out         = ex_q.rd;
    reg_write_out       = ex_q.reg_write & ex_q.valid;
    mem_read_out        = ex_q.mem_read & ex_q.valid;
    mem_write_out       = ex_q.mem_write & ex_q.valid;
    ex_valid_out        = ex_q.valid;
    load_use_stall_out  = load_use;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the RV32 core. It captures decoded operands and control from the decode stage and presents them to the ALU operand mux and ALU in EX. It also applies EX-stage operand forwarding from EX/MEM and MEM/WB, and detects load-use hazards by inserting one bubble. Stall and flush from the pipeline control are applied here.

## Interface
Parameters
- XLEN, 32, datapath width.

Ports
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stall_in  in  1  global freeze from downstream (e.g. memory wait).
- flush_in  in  1  kill EX contents (branch/jump redirect).
- id_valid_in  in  1  decode-stage instruction valid.
- pc_id_in  in  XLEN  decode-stage PC.
- rs1_addr_in, rs2_addr_in, rd_addr_in  in  5 each  register indices.
- reg_1_id_in, reg_2_id_in  in  XLEN  register-file read data.
- imm_data_id_in  in  XLEN  sign-extended immediate.
- alu_op_id_in  in  5  ALU operation code.
- alu_mode_select_id_in  in  2  operand-mux select (00 R, 01 I, 10 AUIPC, 11 LUI).
- reg_write_id_in, mem_read_id_in, mem_write_id_in  in  1 each  control bits.
- ex_mem_rd_in  in  5  destination index of the instruction in MEM.
- ex_mem_reg_write_in  in  1  MEM-stage instruction writes rd.
- ex_mem_result_in  in  XLEN  MEM-stage ALU result.
- mem_wb_rd_in  in  5  destination index of the instruction in WB.
- mem_wb_reg_write_in  in  1  WB-stage instruction writes rd.
- mem_wb_result_in  in  XLEN  WB write-back data.
- pc_ex  out  XLEN  registered PC.
- reg_1_out, reg_2_out  out  XLEN  forwarded operands.
- imm_data_out  out  XLEN  registered immediate.
- alu_op_out  out  5  registered ALU op.
- alu_mode_select_out  out  2  registered mux select.
- rd_addr_out  out  5  registered destination index.
- reg_write_out, mem_read_out, mem_write_out  out  1 each  registered control, gated by valid.
- ex_valid_out  out  1  EX slot holds a live instruction.
- load_use_stall_out  out  1  request to IF/ID: hold the decode instruction this cycle.

## Operation
- Registered state: valid, pc, rs1/rs2/rd indices, reg_1, reg_2, imm, alu_op, alu_mode_select, reg_write, mem_read, mem_write.
- Update priority on each rising clk edge:
  1. rst: all state cleared to 0.
  2. flush_in: bubble. valid and all control bits go to 0; data fields go to 0.
  3. stall_in: hold all state.
  4. load_use_stall_out: bubble, with the same clearing as flush.
  5. Otherwise capture all ID inputs; valid <= id_valid_in.
- Hazard: load_use_stall_out = ex_valid & mem_read_ex & (rd_ex != 0) & id_valid_in & ((rs1_addr_in == rd_ex) | (rs2_addr_in == rd_ex)).
  - The rs2 comparison applies even for I-type instructions. This conservative stall is intended.
- Forwarding for operand 1, using the registered rs1 index; operand 2 is identical with rs2:
  - If rs1_ex != 0, ex_mem_reg_write_in is set, and ex_mem_rd_in == rs1_ex: use ex_mem_result_in.
  - Else if rs1_ex != 0, mem_wb_reg_write_in is set, and mem_wb_rd_in == rs1_ex: use mem_wb_result_in.
  - Else use the registered reg_1.
  - EX/MEM takes priority over MEM/WB, so the youngest producer wins.
- Forwarding applies only to register operands; imm_data_out and pc_ex are never forwarded.
- reg_write_out, mem_read_out and mem_write_out are the registered bits ANDed with valid.

## Timing
- Reset value of every output: 0. This covers pc_ex, the operands, imm, alu_op, mode select, rd, all control bits, ex_valid_out and load_use_stall_out.
  - Forwarded operands read 0 unless a forwarding source matches a nonzero index. After reset the indices are 0, so no source can match.
- Latency: ID inputs appear on the registered outputs one cycle after capture.
- Forwarding muxes and load_use_stall_out are combinational in the same cycle, with no added latency.
- Load-use: exactly one bubble. The cycle after the bubble, the load is in WB and the dependent instruction enters EX and takes mem_wb_result_in.
- stall_in and a load-use condition in the same cycle: the register holds and no bubble is inserted. load_use_stall_out stays asserted while the condition persists.
- flush_in and stall_in together: flush wins and a bubble is written.
- rst asserted mid-operation clears state immediately, without waiting for a clock edge.

## Test plan
- Reset: assert rst with the clock idle → all outputs 0 immediately, including ex_valid_out.
- Capture: id_valid_in=1, pc_id_in=0x100, reg_1_id_in=5, imm=0xFFFFFFFC, alu_op=ADD → next cycle pc_ex=0x100, reg_1_out=5, imm_data_out=0xFFFFFFFC, ex_valid_out=1.
- Forward priority: EX holds rs1=3; ex_mem rd=3 with result 0xAA; mem_wb rd=3 with result 0xBB → reg_1_out=0xAA. Drop ex_mem_reg_write_in → reg_1_out=0xBB. With rs1=0 → no forwarding.
- Load-use: EX holds a load with rd=7; ID presents rs2=7 → load_use_stall_out=1 and the next cycle is a bubble (ex_valid_out=0, reg_write_out=0). Then the dependent instruction captures with reg_2_out = mem_wb_result_in.
- Stall/flush: with stall_in=1 for 3 cycles, all outputs are held. Assert flush_in together with stall_in → the next cycle has ex_valid_out=0 and mem_write_out=0.
